// File: rtl/sh1_pkg.sv
// Shared types and sizes for the writeback stage: register file geometry,
// register address type and load size encoding.
package sh1_pkg;

   localparam int REG_WIDTH = 32;
   localparam int REG_COUNT = 16;

   typedef logic [3:0] reg_addr_t;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_WORD = 2'd1,
      SZ_LONG = 2'd2
   } ld_size_e;

endpackage

// File: rtl/writeback_unit_if.sv
// Result sources feeding the writeback stage: ALU result handshake, load
// result handshake and the decoder's destination claim strobe.
// master = producers (execute/decoder), slave = writeback unit.
interface writeback_unit_if #(
   parameter int REG_WIDTH = sh1_pkg::REG_WIDTH
);

   logic                  alu_valid;
   logic                  alu_ready;
   sh1_pkg::reg_addr_t    alu_rd;
   logic [REG_WIDTH-1:0]  alu_data;

   logic                  ld_valid;
   logic                  ld_ready;
   sh1_pkg::reg_addr_t    ld_rd;
   logic [REG_WIDTH-1:0]  ld_data;
   logic [1:0]            ld_size;

   logic                  claim_valid;
   sh1_pkg::reg_addr_t    claim_rd;

   modport master (
      output alu_valid, alu_rd, alu_data,
      input  alu_ready,
      output ld_valid, ld_rd, ld_data, ld_size,
      input  ld_ready,
      output claim_valid, claim_rd
   );

   modport slave (
      input  alu_valid, alu_rd, alu_data,
      output alu_ready,
      input  ld_valid, ld_rd, ld_data, ld_size,
      output ld_ready,
      input  claim_valid, claim_rd
   );

endinterface

// File: rtl/wb_scoreboard_chk.sv
// Illegal pending-counter events: a claim on a register that already has
// three outstanding writes, or a commit on a register with none outstanding.
module wb_scoreboard_chk #(
   parameter int REG_COUNT = sh1_pkg::REG_COUNT
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [REG_COUNT-1:0] claim_ovf,
   input  logic [REG_COUNT-1:0] commit_unf
);

   a_claim_ovf : assert property (@(posedge clk) disable iff (!rst_n)
      claim_ovf == {REG_COUNT{1'b0}});

   a_commit_unf : assert property (@(posedge clk) disable iff (!rst_n)
      commit_unf == {REG_COUNT{1'b0}});

endmodule

// File: rtl/writeback_unit_scoreboard.sv
// Per-register pending-write scoreboard. Each register keeps a 2-bit count of
// claimed-but-not-committed writes; busy_mask flags the nonzero counts.
// Overflow saturates at 3 and underflow floors at 0.
module wb_scoreboard #(
   parameter int REG_COUNT = sh1_pkg::REG_COUNT
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 claim_valid,
   input  sh1_pkg::reg_addr_t   claim_rd,
   input  logic                 commit_valid,
   input  sh1_pkg::reg_addr_t   commit_rd,
   output logic [REG_COUNT-1:0] busy_mask
);

   import sh1_pkg::*;

   logic [1:0]           cnt_r       [REG_COUNT];
   logic [1:0]           cnt_next_s  [REG_COUNT];
   logic [REG_COUNT-1:0] busy_r;
   logic [REG_COUNT-1:0] busy_next_s;
   logic [REG_COUNT-1:0] claim_hit_s;
   logic [REG_COUNT-1:0] commit_hit_s;
   logic [REG_COUNT-1:0] ovf_s;
   logic [REG_COUNT-1:0] unf_s;

   // Next pending count per register; a claim and commit together cancel out
   always_comb begin
      for (int i = 0; i < REG_COUNT; i++) begin
         claim_hit_s[i]  = claim_valid  && (claim_rd  == reg_addr_t'(i));
         commit_hit_s[i] = commit_valid && (commit_rd == reg_addr_t'(i));
         cnt_next_s[i]   = cnt_r[i];
         ovf_s[i]        = 1'b0;
         unf_s[i]        = 1'b0;
         if (claim_hit_s[i] && !commit_hit_s[i]) begin
            if (cnt_r[i] == 2'd3) begin
               ovf_s[i] = 1'b1;
            end else begin
               cnt_next_s[i] = cnt_r[i] + 2'd1;
            end
         end else if (commit_hit_s[i] && !claim_hit_s[i]) begin
            if (cnt_r[i] == 2'd0) begin
               unf_s[i] = 1'b1;
            end else begin
               cnt_next_s[i] = cnt_r[i] - 2'd1;
            end
         end else begin
            cnt_next_s[i] = cnt_r[i];
         end
         busy_next_s[i] = (cnt_next_s[i] != 2'd0);
      end
   end

   // Pending counters and registered busy mask
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < REG_COUNT; i++) begin
            cnt_r[i] <= 2'd0;
         end
         busy_r <= {REG_COUNT{1'b0}};
      end else begin
         for (int i = 0; i < REG_COUNT; i++) begin
            cnt_r[i] <= cnt_next_s[i];
         end
         busy_r <= busy_next_s;
      end
   end

   assign busy_mask = busy_r;

   wb_scoreboard_chk #(.REG_COUNT(REG_COUNT)) u_chk (
      .clk        (clk),
      .rst_n      (rst_n),
      .claim_ovf  (ovf_s),
      .commit_unf (unf_s)
   );

endmodule

// File: rtl/writeback_unit.sv
// Writeback stage: arbitrates between load and ALU results (load first, ALU
// promoted after STARVE_LIMIT lost cycles), sign-extends loads, registers the
// single register-bank write, and tracks pending destinations.
// Optional macro WB_FORWARD_EN adds fwd_valid/fwd_addr/fwd_data, a copy of
// the write port for same-cycle operand bypass.
module writeback_unit #(
   parameter int REG_WIDTH    = sh1_pkg::REG_WIDTH,
   parameter int REG_COUNT    = sh1_pkg::REG_COUNT,
   parameter int STARVE_LIMIT = 3
) (
   input  logic                 clk,
   input  logic                 rst_n,
   writeback_unit_if.slave      wb,
   output logic                 rb_we,
   output sh1_pkg::reg_addr_t   rb_waddr,
   output logic [REG_WIDTH-1:0] rb_wdata,
   output logic [REG_COUNT-1:0] busy_mask
`ifdef WB_FORWARD_EN
   ,
   output logic                 fwd_valid,
   output sh1_pkg::reg_addr_t   fwd_addr,
   output logic [REG_WIDTH-1:0] fwd_data
`endif
);

   import sh1_pkg::*;

   localparam int            SW         = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

   // Sign-extend a right-aligned load value according to its access size
   function automatic logic [REG_WIDTH-1:0] sext_load(
      input logic [REG_WIDTH-1:0] raw,
      input logic [1:0]           size
   );
      logic [REG_WIDTH-1:0] res;
      case (size)
         SZ_BYTE: res = {{(REG_WIDTH - 8){raw[7]}}, raw[7:0]};
         SZ_WORD: res = {{(REG_WIDTH - 16){raw[15]}}, raw[15:0]};
         default: res = raw;
      endcase
      return res;
   endfunction

   logic                 ld_sel_s;
   logic                 alu_sel_s;
   logic                 alu_starved_s;
   logic [SW-1:0]        starve_r;
   logic [SW-1:0]        starve_next_s;
   logic                 rb_we_r;
   reg_addr_t            rb_waddr_r;
   logic [REG_WIDTH-1:0] rb_wdata_r;
   logic                 we_next_s;
   reg_addr_t            waddr_next_s;
   logic [REG_WIDTH-1:0] wdata_next_s;

   // Pick at most one source: load wins unless the ALU has starved
   always_comb begin
      ld_sel_s      = 1'b0;
      alu_sel_s     = 1'b0;
      alu_starved_s = wb.alu_valid && (starve_r == STARVE_MAX);
      if (!rst_n) begin
         ld_sel_s  = 1'b0;
         alu_sel_s = 1'b0;
      end else if (wb.ld_valid && !alu_starved_s) begin
         ld_sel_s = 1'b1;
      end else if (wb.alu_valid) begin
         alu_sel_s = 1'b1;
      end else begin
         ld_sel_s  = 1'b0;
         alu_sel_s = 1'b0;
      end
   end

   assign wb.ld_ready  = ld_sel_s;
   assign wb.alu_ready = alu_sel_s;

   // Starvation count: grows while the ALU waits, clears once it stops waiting
   always_comb begin
      starve_next_s = {SW{1'b0}};
      if (wb.alu_valid && !alu_sel_s) begin
         if (starve_r == STARVE_MAX) begin
            starve_next_s = STARVE_MAX;
         end else begin
            starve_next_s = starve_r + {{(SW - 1){1'b0}}, 1'b1};
         end
      end else begin
         starve_next_s = {SW{1'b0}};
      end
   end

   // Next register-bank write from whichever source was accepted
   always_comb begin
      we_next_s    = 1'b0;
      waddr_next_s = rb_waddr_r;
      wdata_next_s = rb_wdata_r;
      if (ld_sel_s) begin
         we_next_s    = 1'b1;
         waddr_next_s = wb.ld_rd;
         wdata_next_s = sext_load(wb.ld_data, wb.ld_size);
      end else if (alu_sel_s) begin
         we_next_s    = 1'b1;
         waddr_next_s = wb.alu_rd;
         wdata_next_s = wb.alu_data;
      end else begin
         we_next_s = 1'b0;
      end
   end

   // Write port and starvation state; reset drops any in-flight write
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rb_we_r    <= 1'b0;
         rb_waddr_r <= 4'd0;
         rb_wdata_r <= {REG_WIDTH{1'b0}};
         starve_r   <= {SW{1'b0}};
      end else begin
         rb_we_r    <= we_next_s;
         rb_waddr_r <= waddr_next_s;
         rb_wdata_r <= wdata_next_s;
         starve_r   <= starve_next_s;
      end
   end

   assign rb_we    = rb_we_r;
   assign rb_waddr = rb_waddr_r;
   assign rb_wdata = rb_wdata_r;

`ifdef WB_FORWARD_EN
   assign fwd_valid = rb_we_r;
   assign fwd_addr  = rb_waddr_r;
   assign fwd_data  = rb_wdata_r;
`endif

   wb_scoreboard #(.REG_COUNT(REG_COUNT)) u_scoreboard (
      .clk          (clk),
      .rst_n        (rst_n),
      .claim_valid  (wb.claim_valid),
      .claim_rd     (wb.claim_rd),
      .commit_valid (rb_we_r),
      .commit_rd    (rb_waddr_r),
      .busy_mask    (busy_mask)
   );

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: reset values, load sign extension, ALU
// pass-through, load/ALU arbitration with starvation, pending scoreboard and
// reset mid-operation. Forwarding outputs are checked when WB_FORWARD_EN is set.
module tb_writeback_unit;

   logic               clk;
   logic               rst_n;
   logic               rb_we;
   sh1_pkg::reg_addr_t rb_waddr;
   logic [31:0]        rb_wdata;
   logic [15:0]        busy_mask;
`ifdef WB_FORWARD_EN
   logic               fwd_valid;
   sh1_pkg::reg_addr_t fwd_addr;
   logic [31:0]        fwd_data;
`endif

   int tests_run    = 0;
   int tests_failed = 0;

   writeback_unit_if #(.REG_WIDTH(32)) wb_if ();

   writeback_unit #(
      .REG_WIDTH    (32),
      .REG_COUNT    (16),
      .STARVE_LIMIT (3)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .wb        (wb_if),
      .rb_we     (rb_we),
      .rb_waddr  (rb_waddr),
      .rb_wdata  (rb_wdata),
      .busy_mask (busy_mask)
`ifdef WB_FORWARD_EN
      ,
      .fwd_valid (fwd_valid),
      .fwd_addr  (fwd_addr),
      .fwd_data  (fwd_data)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_claim(input logic [3:0] rd);
      wb_if.claim_valid = 1'b1;
      wb_if.claim_rd    = rd;
      tick();
      wb_if.claim_valid = 1'b0;
   endtask

   // Load with a same-cycle claim of its destination
   task automatic do_load(input logic [3:0] rd, input logic [31:0] data,
                          input logic [1:0] size, input logic [31:0] exp);
      wb_if.claim_valid = 1'b1;
      wb_if.claim_rd    = rd;
      wb_if.ld_valid    = 1'b1;
      wb_if.ld_rd       = rd;
      wb_if.ld_data     = data;
      wb_if.ld_size     = size;
      #1;
      check_eq("ld_ready", wb_if.ld_ready, 1);
      check_eq("alu_ready_during_ld", wb_if.alu_ready, 0);
      tick();
      wb_if.claim_valid = 1'b0;
      wb_if.ld_valid    = 1'b0;
      check_eq("ld_we", rb_we, 1);
      check_eq("ld_waddr", rb_waddr, rd);
      check_eq("ld_wdata", rb_wdata, exp);
   endtask

   task automatic do_alu(input logic [3:0] rd, input logic [31:0] data, input logic clm);
      wb_if.claim_valid = clm;
      wb_if.claim_rd    = rd;
      wb_if.alu_valid   = 1'b1;
      wb_if.alu_rd      = rd;
      wb_if.alu_data    = data;
      #1;
      check_eq("alu_ready", wb_if.alu_ready, 1);
      check_eq("ld_ready_during_alu", wb_if.ld_ready, 0);
      tick();
      wb_if.claim_valid = 1'b0;
      wb_if.alu_valid   = 1'b0;
      check_eq("alu_we", rb_we, 1);
      check_eq("alu_waddr", rb_waddr, rd);
      check_eq("alu_wdata", rb_wdata, data);
`ifdef WB_FORWARD_EN
      check_eq("fwd_valid", fwd_valid, 1);
      check_eq("fwd_addr", fwd_addr, rd);
      check_eq("fwd_data", fwd_data, data);
`endif
   endtask

   initial begin
      rst_n             = 1'b0;
      wb_if.alu_valid   = 1'b0;
      wb_if.alu_rd      = 4'd0;
      wb_if.alu_data    = 32'd0;
      wb_if.ld_valid    = 1'b0;
      wb_if.ld_rd       = 4'd0;
      wb_if.ld_data     = 32'd0;
      wb_if.ld_size     = 2'd0;
      wb_if.claim_valid = 1'b0;
      wb_if.claim_rd    = 4'd0;

      // Reset state, readies held low even with both sources valid
      tick();
      tick();
      wb_if.alu_valid = 1'b1;
      wb_if.ld_valid  = 1'b1;
      #1;
      check_eq("rst_alu_ready", wb_if.alu_ready, 0);
      check_eq("rst_ld_ready", wb_if.ld_ready, 0);
      check_eq("rst_we", rb_we, 0);
      check_eq("rst_waddr", rb_waddr, 0);
      check_eq("rst_wdata", rb_wdata, 0);
      check_eq("rst_busy", busy_mask, 0);
      wb_if.alu_valid = 1'b0;
      wb_if.ld_valid  = 1'b0;
      rst_n           = 1'b1;
      tick();
      check_eq("idle_we", rb_we, 0);

      // Load sign extension across sizes
      do_load(4'd5, 32'h0000_0080, 2'd0, 32'hFFFF_FF80);
      check_eq("busy_r5", busy_mask, 16'h0020);
      do_load(4'd1, 32'h0000_8001, 2'd1, 32'hFFFF_8001);
      check_eq("busy_r1", busy_mask, 16'h0002);
      do_load(4'd1, 32'h8000_00FF, 2'd2, 32'h8000_00FF);
      check_eq("busy_r1_claim_commit", busy_mask, 16'h0002);
      do_load(4'd1, 32'h7FFF_0001, 2'd3, 32'h7FFF_0001);
      do_load(4'd12, 32'h0000_017F, 2'd0, 32'h0000_007F);

      // ALU results pass unmodified
      do_alu(4'd2, 32'h1234_5678, 1'b1);
      do_alu(4'd4, 32'h0000_0080, 1'b1);
      tick();
      check_eq("idle_we_after_alu", rb_we, 0);
      check_eq("busy_drained", busy_mask, 0);

      // Arbitration: ALU promoted after three lost cycles
      do_claim(4'd8);
      do_claim(4'd8);
      do_claim(4'd8);
      do_claim(4'd9);
      check_eq("busy_r8_r9", busy_mask, 16'h0300);
      wb_if.ld_valid  = 1'b1;
      wb_if.ld_rd     = 4'd8;
      wb_if.ld_data   = 32'h0000_0011;
      wb_if.ld_size   = 2'd2;
      wb_if.alu_valid = 1'b1;
      wb_if.alu_rd    = 4'd9;
      wb_if.alu_data  = 32'h0000_0099;
      for (int k = 0; k < 3; k++) begin
         #1;
         check_eq("arb_ld_ready", wb_if.ld_ready, 1);
         check_eq("arb_alu_wait", wb_if.alu_ready, 0);
         tick();
         check_eq("arb_ld_waddr", rb_waddr, 8);
      end
      #1;
      check_eq("starve_alu_ready", wb_if.alu_ready, 1);
      check_eq("starve_ld_wait", wb_if.ld_ready, 0);
      tick();
      check_eq("starve_alu_waddr", rb_waddr, 9);
      check_eq("starve_alu_wdata", rb_wdata, 32'h0000_0099);
      wb_if.ld_rd       = 4'd10;
      wb_if.claim_valid = 1'b1;
      wb_if.claim_rd    = 4'd10;
      #1;
      check_eq("starve_cleared_ld_ready", wb_if.ld_ready, 1);
      check_eq("starve_cleared_alu_wait", wb_if.alu_ready, 0);
      tick();
      wb_if.claim_valid = 1'b0;
      wb_if.ld_valid    = 1'b0;
      wb_if.alu_valid   = 1'b0;
      check_eq("starve_cleared_waddr", rb_waddr, 10);
      tick();
      check_eq("busy_after_arb", busy_mask, 0);

      // Two claims on R3 need two commits
      do_claim(4'd3);
      do_claim(4'd3);
      check_eq("busy_r3_two", busy_mask, 16'h0008);
      do_alu(4'd3, 32'h0000_0033, 1'b0);
      tick();
      check_eq("busy_r3_one", busy_mask, 16'h0008);
      do_alu(4'd3, 32'h0000_0034, 1'b0);
      tick();
      check_eq("busy_r3_zero", busy_mask, 0);

      // Claim and commit of R7 in the same cycle leave it pending
      do_claim(4'd7);
      check_eq("busy_r7", busy_mask, 16'h0080);
      do_alu(4'd7, 32'h0000_0077, 1'b0);
      wb_if.claim_valid = 1'b1;
      wb_if.claim_rd    = 4'd7;
      tick();
      wb_if.claim_valid = 1'b0;
      check_eq("busy_r7_same_cycle", busy_mask, 16'h0080);
      do_alu(4'd7, 32'h0000_0078, 1'b0);
      tick();
      check_eq("busy_r7_zero", busy_mask, 0);

      // Reset right after an accept discards the pending write
      do_claim(4'd6);
      do_alu(4'd6, 32'h0000_0066, 1'b0);
      rst_n           = 1'b0;
      wb_if.alu_valid = 1'b1;
      wb_if.ld_valid  = 1'b1;
      #1;
      check_eq("midrst_alu_ready", wb_if.alu_ready, 0);
      check_eq("midrst_ld_ready", wb_if.ld_ready, 0);
      tick();
      check_eq("midrst_we", rb_we, 0);
      check_eq("midrst_busy", busy_mask, 0);
      check_eq("midrst_wdata", rb_wdata, 0);
      wb_if.alu_valid = 1'b0;
      wb_if.ld_valid  = 1'b0;
      rst_n           = 1'b1;
      tick();
      check_eq("postrst_we", rb_we, 0);
      check_eq("postrst_busy", busy_mask, 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
